// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits MSB first, STOP_BITS stop bits.
// Words arrive over valid/ready; a final-stop-cycle handshake chains frames with no gap.
module uart_tx #(
    parameter int WIDTH     = 8,
    parameter int DIVISOR   = 100,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);
    // state | meaning
    // IDLE  | line high, waiting for a word
    // START | start bit (low) for DIVISOR cycles
    // DATA  | shifting WIDTH bits out MSB first
    // STOP  | line high for STOP_BITS bit periods
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int PH_W  = $clog2(DIVISOR);
    localparam int BIT_W = $clog2(WIDTH) + 1;
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    state_t           state_q;
    logic [PH_W-1:0]  phase_q;
    logic [BIT_W-1:0] bit_q;
    logic             stop_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             tx_q;
    logic             phase_end;
    logic             last_cycle;
    logic             accept;

    assign phase_end  = (phase_q == PH_LAST);
    assign last_cycle = (state_q == STOP) && phase_end && (stop_q == STOP_LAST);
    assign o_ready    = !i_reset && ((state_q == IDLE) || last_cycle);
    assign o_busy     = !i_reset && (state_q != IDLE);
    assign o_done     = !i_reset && last_cycle;
    assign o_tx       = tx_q;
    assign accept     = i_valid && o_ready;
    assign shift_d    = shift_q << 1;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            // Phase restarts on every bit boundary, so it stays aligned to the handshake.
            phase_q <= phase_end ? '0 : phase_q + 1'b1;
            case (state_q)
                IDLE: begin
                    phase_q <= '0;
                    if (accept) begin
                        state_q <= START;
                        shift_q <= i_data;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (phase_end) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[WIDTH-1];
                    end
                end
                DATA: begin
                    if (phase_end) begin
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                            stop_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_d;
                            tx_q    <= shift_d[WIDTH-1];
                        end
                    end
                end
                STOP: begin
                    if (phase_end) begin
                        if (stop_q == STOP_LAST) begin
                            if (accept) begin
                                state_q <= START;
                                shift_q <= i_data;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line checks from a vector table, hand-written corner
// sequences, and an independent serial receiver model fed by a word scoreboard.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_data, i_data2;
    logic       i_valid, i_valid2;
    logic       o_ready, o_tx, o_busy, o_done;
    logic       o_ready2, o_tx2, o_busy2, o_done2;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb_q[$];
    int         rx_frames = 0;
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_shift = '0;

    typedef struct {
        logic [7:0] data;
        logic       noise;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(8), .DIVISOR(4), .STOP_BITS(1)) dut (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    uart_tx #(.WIDTH(8), .DIVISOR(3), .STOP_BITS(2)) dut2 (
        .clk(clk), .i_reset(i_reset), .i_data(i_data2), .i_valid(i_valid2),
        .o_ready(o_ready2), .o_tx(o_tx2), .o_busy(o_busy2), .o_done(o_done2)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Receiver model: mid-bit sampling, one bit period = D cycles.
    always @(posedge clk) begin
        #1;
        if (i_reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (o_tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= D && rx_cnt < 9 * D && (rx_cnt % D) == D / 2) begin
                rx_shift = {rx_shift[6:0], o_tx};
            end else if (rx_cnt == 9 * D + D / 2) begin
                check("rx_stop", o_tx, 1);
                check("rx_word_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check("rx_data", rx_shift, sb_q.pop_front());
                rx_frames++;
                rx_active = 1'b0;
            end
        end
    end

    task automatic run_frame(input logic [7:0] data, input logic noise, input logic [9:0] frame);
        check("idle_ready", o_ready, 1);
        check("idle_tx", o_tx, 1);
        i_data = data;
        i_valid = 1'b1;
        sb_q.push_back(data);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check($sformatf("tx c=%0d", c), o_tx, frame[9 - c / D]);
            check($sformatf("done c=%0d", c), o_done, c == 39);
            check($sformatf("ready c=%0d", c), o_ready, c == 39);
            check($sformatf("busy c=%0d", c), o_busy, 1);
            if (noise && c < 39) begin
                i_valid = 1'b1;
                i_data = 8'hFF;
            end else begin
                i_valid = 1'b0;
                i_data = 8'($urandom);
            end
        end
        @(negedge clk);
        check("post_frame_busy", o_busy, 0);
        check("post_frame_tx", o_tx, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] bb;
        logic [10:0] f2;
        logic [9:0]  f81;
        int dn;
        int start_frames;
        int k;

        vecs[0] = '{8'hA5, 1'b0, 10'b0101001011};
        vecs[1] = '{8'h3C, 1'b1, 10'b0001111001};
        vecs[2] = '{8'h00, 1'b0, 10'b0000000001};
        vecs[3] = '{8'hC3, 1'b1, 10'b0110000111};

        i_reset = 1'b1; i_valid = 1'b0; i_data = '0; i_valid2 = 1'b0; i_data2 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", o_tx, 1);
        check("rst_ready", o_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_tx2", o_tx2, 1);
        i_reset = 1'b0;
        @(negedge clk);
        check("after_rst_ready", o_ready, 1);
        check("after_rst_busy", o_busy, 0);

        for (int v = 0; v < 4; v++) run_frame(vecs[v].data, vecs[v].noise, vecs[v].frame);

        // Back-to-back 0x00 then 0xFF with i_valid held high.
        bb = {10'b0000000001, 10'b0111111111};
        dn = 0;
        i_data = 8'h00; i_valid = 1'b1; sb_q.push_back(8'h00);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            check($sformatf("b2b tx c=%0d", c), o_tx, bb[19 - c / D]);
            check($sformatf("b2b busy c=%0d", c), o_busy, 1);
            if (o_done) dn++;
            if (c == 0) begin i_data = 8'hFF; sb_q.push_back(8'hFF); end
            if (c == 79) i_valid = 1'b0;
        end
        check("b2b_done_count", dn, 2);
        @(negedge clk);
        check("b2b_idle_busy", o_busy, 0);

        // Reset during data bit 3 of 0x81.
        f81 = 10'b0100000011;
        i_data = 8'h81; i_valid = 1'b1; sb_q.push_back(8'h81);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) i_valid = 1'b0;
            check($sformatf("rst_frame tx c=%0d", c), o_tx, f81[9 - c / D]);
        end
        i_reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("midrst_tx", o_tx, 1);
        check("midrst_busy", o_busy, 0);
        check("midrst_ready", o_ready, 0);
        check("midrst_done", o_done, 0);
        i_reset = 1'b0;
        @(negedge clk);
        check("midrst_after_ready", o_ready, 1);
        check("midrst_after_busy", o_busy, 0);
        check("midrst_after_tx", o_tx, 1);
        run_frame(8'h42, 1'b0, 10'b0010000101);

        // Two stop bits, DIVISOR=3: 33-cycle frame, stop level 6 cycles.
        f2 = 11'b00000000111;
        i_data2 = 8'h01; i_valid2 = 1'b1;
        for (int c = 0; c < 33; c++) begin
            @(negedge clk);
            if (c == 0) i_valid2 = 1'b0;
            check($sformatf("sb2 tx c=%0d", c), o_tx2, f2[10 - c / 3]);
            check($sformatf("sb2 done c=%0d", c), o_done2, c == 32);
            check($sformatf("sb2 ready c=%0d", c), o_ready2, c == 32);
        end
        @(negedge clk);
        check("sb2_idle_busy", o_busy2, 0);
        check("sb2_idle_tx", o_tx2, 1);

        // All 256 values back-to-back into the receiver model.
        start_frames = rx_frames;
        for (int v = 0; v < 256; v++) begin
            k = 0;
            i_data = v[7:0];
            i_valid = 1'b1;
            while (!o_ready && k < 60) begin
                @(negedge clk);
                k++;
            end
            check("loop_ready_timeout", o_ready, 1);
            if (!o_ready) break;
            sb_q.push_back(v[7:0]);
            @(negedge clk);
        end
        i_valid = 1'b0;
        k = 0;
        while ((sb_q.size() != 0 || rx_active) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("loop_frames", rx_frames - start_frames, 256);
        check("loop_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
